qspi_rx_shift_reg: RTL and testbench

Receive-side deserializer for the QSPI controller, the counterpart of the transmit shift register. It samples the IO lines on strobes from the SCLK generator in 1-, 2- or 4-line mode, assembles MSB-first bytes into 32-bit words, and presents each word to the AHB/FIFO side through a valid/ready output register. It tracks the programmed transfer byte length, flags the last (possibly partial) word, and reports overruns.

---
 rtl/qspi_rx_shift_reg.sv | 180 ++++++++++++++++++
 tb/tb_qspi_rx_shift_reg.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/qspi_rx_shift_reg.sv
// QSPI receive deserializer: samples 1/2/4 IO lines into MSB-first bytes, packs words behind a valid/ready register.
// Optional QSPI_RX_HOLD_EN adds sclk_hold, which asks the SCLK generator to pause before an overrun.
module qspi_rx_shift_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] xfer_len,
  input  logic        sample_en,
  input  logic        use_1_io_lines_in,
  input  logic        use_2_io_lines_in,
  input  logic        use_4_io_lines_in,
  input  logic        qspi_io0,
  input  logic        qspi_io1,
  input  logic        qspi_io2,
  input  logic        qspi_io3,
  output logic [31:0] rx_data,
  output logic [2:0]  rx_nbytes,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic        rx_last,
  output logic        busy,
  output logic        done,
`ifdef QSPI_RX_HOLD_EN
  output logic        sclk_hold,
`endif
  output logic        overflow
);

  localparam int DATA_W = 32;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RX   = 1'b1;

  localparam logic [1:0] M_SINGLE = 2'd0;
  localparam logic [1:0] M_DUAL   = 2'd1;
  localparam logic [1:0] M_QUAD   = 2'd2;

  logic [0:0]        r_state;
  logic [1:0]        r_mode;
  logic [7:0]        r_shreg;
  logic [2:0]        r_bitcnt;
  logic [1:0]        r_slot;
  logic [15:0]       r_bytes_rem;
  logic [DATA_W-1:0] r_word;
  logic [DATA_W-1:0] r_rx_data;
  logic [2:0]        r_rx_nbytes;
  logic              r_rx_valid;
  logic              r_rx_last;
  logic              r_done;
  logic              r_overflow;

  logic [3:0]        w_step;
  logic [7:0]        w_shreg_next;
  logic [3:0]        w_bit_sum;
  logic              w_byte_done;
  logic              w_word_done;
  logic [15:0]       w_rem_next;
  logic [DATA_W-1:0] w_word_next;
  logic              w_sample;
  logic              w_consume;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_step       = 4'd1;
    w_shreg_next = {r_shreg[6:0], qspi_io1};
    case (r_mode)
      M_QUAD: begin
        w_step       = 4'd4;
        w_shreg_next = {r_shreg[3:0], qspi_io3, qspi_io2, qspi_io1, qspi_io0};
      end
      M_DUAL: begin
        w_step       = 4'd2;
        w_shreg_next = {r_shreg[5:0], qspi_io1, qspi_io0};
      end
      default: ;
    endcase
  end

  assign w_bit_sum   = {1'b0, r_bitcnt} + w_step;
  assign w_byte_done = w_bit_sum[3];
  assign w_rem_next  = r_bytes_rem - 16'd1;
  // Word closes on the 4th byte or on the final byte of the transfer, whichever comes first.
  assign w_word_done = w_byte_done && ((r_slot == 2'd3) || (r_bytes_rem == 16'd1));
  assign w_sample    = (r_state == S_RX) && sample_en;
  assign w_consume   = r_rx_valid && rx_ready;

  always_comb begin
    w_word_next = r_word;
    case (r_slot)
      2'd0:    w_word_next[31:24] = w_shreg_next;
      2'd1:    w_word_next[23:16] = w_shreg_next;
      2'd2:    w_word_next[15:8]  = w_shreg_next;
      default: w_word_next[7:0]   = w_shreg_next;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_mode      <= M_SINGLE;
      r_shreg     <= '0;
      r_bitcnt    <= '0;
      r_slot      <= '0;
      r_bytes_rem <= '0;
      r_word      <= '0;
      r_rx_data   <= '0;
      r_rx_nbytes <= '0;
      r_rx_valid  <= 1'b0;
      r_rx_last   <= 1'b0;
      r_done      <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_consume) begin
        r_rx_valid <= 1'b0;
        r_rx_last  <= 1'b0;
      end

      if (start) begin
        r_mode      <= use_4_io_lines_in ? M_QUAD :
                       use_2_io_lines_in ? M_DUAL : M_SINGLE;
        r_shreg     <= '0;
        r_bitcnt    <= '0;
        r_slot      <= '0;
        r_word      <= '0;
        r_bytes_rem <= xfer_len;
        r_overflow  <= 1'b0;
        if (xfer_len == 16'd0) begin
          r_state <= S_IDLE;
          r_done  <= 1'b1;
        end else begin
          r_state <= S_RX;
        end
      end else if (w_sample) begin
        r_shreg  <= w_shreg_next;
        r_bitcnt <= w_bit_sum[2:0];
        if (w_byte_done) begin
          r_bytes_rem <= w_rem_next;
          if (w_word_done) begin
            r_slot <= '0;
            r_word <= '0;
            if (!r_rx_valid || rx_ready) begin
              r_rx_data   <= w_word_next;
              r_rx_nbytes <= {1'b0, r_slot} + 3'd1;
              r_rx_valid  <= 1'b1;
              r_rx_last   <= (w_rem_next == 16'd0);
            end else begin
              r_overflow <= 1'b1;
            end
            if (w_rem_next == 16'd0) begin
              r_state <= S_IDLE;
              r_done  <= 1'b1;
            end
          end else begin
            r_slot <= r_slot + 2'd1;
            r_word <= w_word_next;
          end
        end
      end
    end
  end

  assign rx_data   = r_rx_data;
  assign rx_nbytes = r_rx_nbytes;
  assign rx_valid  = r_rx_valid;
  assign rx_last   = r_rx_last;
  assign busy      = (r_state == S_RX);
  assign done      = r_done;
  assign overflow  = r_overflow;

`ifdef QSPI_RX_HOLD_EN
  assign sclk_hold = (r_state == S_RX) && r_rx_valid && !rx_ready && w_word_done;
`endif

  // Mode inputs are decoded only through the priority chain at start; single is the fallback.
  logic w_unused;
  assign w_unused = use_1_io_lines_in;

endmodule

// File: tb/tb_qspi_rx_shift_reg.sv
// Scoreboard bench for qspi_rx_shift_reg: expected words queued at stimulus time, compared on each handshake.
module tb_qspi_rx_shift_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] xfer_len;
  logic        sample_en;
  logic        use_1, use_2, use_4;
  logic        qspi_io0, qspi_io1, qspi_io2, qspi_io3;
  logic [31:0] rx_data;
  logic [2:0]  rx_nbytes;
  logic        rx_valid;
  logic        rx_ready;
  logic        rx_last;
  logic        busy;
  logic        done;
  logic        overflow;
`ifdef QSPI_RX_HOLD_EN
  logic        sclk_hold;
`endif

  qspi_rx_shift_reg dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .xfer_len         (xfer_len),
    .sample_en        (sample_en),
    .use_1_io_lines_in(use_1),
    .use_2_io_lines_in(use_2),
    .use_4_io_lines_in(use_4),
    .qspi_io0         (qspi_io0),
    .qspi_io1         (qspi_io1),
    .qspi_io2         (qspi_io2),
    .qspi_io3         (qspi_io3),
    .rx_data          (rx_data),
    .rx_nbytes        (rx_nbytes),
    .rx_valid         (rx_valid),
    .rx_ready         (rx_ready),
    .rx_last          (rx_last),
    .busy             (busy),
    .done             (done),
`ifdef QSPI_RX_HOLD_EN
    .sclk_hold        (sclk_hold),
`endif
    .overflow         (overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic [2:0]  nbytes;
    logic        last;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Inputs change #1 after posedge, so the negedge view matches what the next edge will see.
  always @(negedge clk) begin
    if (!rst && rx_valid && rx_ready) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_word", 32'(sb_q.size()), 32'd1);
      end else begin
        mon_e = sb_q.pop_front();
        check("sb_data",   rx_data,          mon_e.data);
        check("sb_nbytes", 32'(rx_nbytes),   32'(mon_e.nbytes));
        check("sb_last",   32'(rx_last),     32'(mon_e.last));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic strobe(input logic [3:0] io);
    {qspi_io3, qspi_io2, qspi_io1, qspi_io0} = io;
    sample_en = 1'b1;
    tick(1);
    sample_en = 1'b0;
  endtask

  task automatic start_xfer(input logic [15:0] len);
    xfer_len = len;
    start    = 1'b1;
    tick(1);
    start    = 1'b0;
  endtask

  // Unused IO lines carry junk so a wrong-width decode corrupts the byte.
  task automatic send_byte(input int lines, input logic [7:0] b);
    case (lines)
      4: begin
        strobe(b[7:4]);
        strobe(b[3:0]);
      end
      2: for (int i = 3; i >= 0; i--) strobe({2'b11, b[2*i+1], b[2*i]});
      default: for (int i = 7; i >= 0; i--) strobe({2'b01, b[i], ~b[i]});
    endcase
  endtask

  task automatic push_exp(input logic [31:0] d, input logic [2:0] nb, input logic last);
    exp_t e;
    e.data = d; e.nbytes = nb; e.last = last;
    sb_q.push_back(e);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_data"},     rx_data,         32'd0);
    check({tag, "_nbytes"},   32'(rx_nbytes),  32'd0);
    check({tag, "_valid"},    32'(rx_valid),   32'd0);
    check({tag, "_last"},     32'(rx_last),    32'd0);
    check({tag, "_busy"},     32'(busy),       32'd0);
    check({tag, "_done"},     32'(done),       32'd0);
    check({tag, "_overflow"}, 32'(overflow),   32'd0);
`ifdef QSPI_RX_HOLD_EN
    check({tag, "_hold"},     32'(sclk_hold),  32'd0);
`endif
  endtask

  logic [7:0] bytes3 [6] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
  logic [7:0] single_b;

  initial begin
    rst = 1'b1; start = 1'b0; xfer_len = '0; sample_en = 1'b0;
    use_1 = 1'b0; use_2 = 1'b0; use_4 = 1'b0; rx_ready = 1'b0;
    {qspi_io3, qspi_io2, qspi_io1, qspi_io0} = 4'h0;
    tick(2);
    check_all_zero("reset");
    rst = 1'b0;
    tick(1);

    // Quad DEADBEEF, consumer stalled so the word can be inspected at N+1.
    use_4 = 1'b1;
    push_exp(32'hDEADBEEF, 3'd4, 1'b1);
    start_xfer(16'd4);
    check("quad_busy_after_start", 32'(busy), 32'd1);
    foreach (bytes3[i]) begin end
    send_byte(4, 8'hDE); send_byte(4, 8'hAD); send_byte(4, 8'hBE); send_byte(4, 8'hEF);
    check("quad_done",   32'(done),      32'd1);
    check("quad_valid",  32'(rx_valid),  32'd1);
    check("quad_data",   rx_data,        32'hDEADBEEF);
    check("quad_nbytes", 32'(rx_nbytes), 32'd4);
    check("quad_last",   32'(rx_last),   32'd1);
    check("quad_busy",   32'(busy),      32'd0);
    tick(1);
    check("quad_done_pulse", 32'(done),     32'd0);
    check("quad_valid_hold", 32'(rx_valid), 32'd1);
    rx_ready = 1'b1;
    tick(1);
    check("quad_valid_clear", 32'(rx_valid), 32'd0);

    // Single mode with no mode input set.
    use_4 = 1'b0;
    push_exp(32'hA5000000, 3'd1, 1'b1);
    start_xfer(16'd1);
    single_b = 8'hA5;
    send_byte(1, single_b);
    check("single_done", 32'(done),     32'd1);
    check("single_data", rx_data,       32'hA5000000);
    check("single_last", 32'(rx_last),  32'd1);
    tick(2);

    // Dual, 6 bytes; mode inputs flip to quad mid-transfer and must be ignored.
    use_2 = 1'b1;
    push_exp(32'h12345678, 3'd4, 1'b0);
    push_exp(32'h9ABC0000, 3'd2, 1'b1);
    start_xfer(16'd6);
    use_2 = 1'b0; use_4 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send_byte(2, bytes3[i]);
      if (i == 2) tick(1);
    end
    check("dual_done",     32'(done),      32'd1);
    check("dual_nbytes",   32'(rx_nbytes), 32'd2);
    check("dual_data",     rx_data,        32'h9ABC0000);
    check("dual_overflow", 32'(overflow),  32'd0);
    tick(2);
    check("dual_sb_drained", 32'(sb_q.size()), 32'd0);

    // Quad 8 bytes, consumer stalled: second word dropped, overflow set.
    rx_ready = 1'b0;
    push_exp(32'h11223344, 3'd4, 1'b0);
    start_xfer(16'd8);
    send_byte(4, 8'h11); send_byte(4, 8'h22); send_byte(4, 8'h33);
    strobe(4'h4);
`ifdef QSPI_RX_HOLD_EN
    check("hold_first_word", 32'(sclk_hold), 32'd0);
`endif
    strobe(4'h4);
    send_byte(4, 8'h55); send_byte(4, 8'h66); send_byte(4, 8'h77);
    strobe(4'h8);
`ifdef QSPI_RX_HOLD_EN
    check("hold_second_word", 32'(sclk_hold), 32'd1);
`endif
    strobe(4'h8);
    check("ovf_flag",  32'(overflow),  32'd1);
    check("ovf_done",  32'(done),      32'd1);
    check("ovf_data",  rx_data,        32'h11223344);
    check("ovf_last",  32'(rx_last),   32'd0);
    check("ovf_valid", 32'(rx_valid),  32'd1);
    rx_ready = 1'b1;
    tick(2);
    check("ovf_sticky", 32'(overflow), 32'd1);
    check("ovf_valid_clear", 32'(rx_valid), 32'd0);

    // Zero-length start: done next cycle, no word, no busy, overflow cleared.
    start_xfer(16'd0);
    check("zero_done",     32'(done),     32'd1);
    check("zero_busy",     32'(busy),     32'd0);
    check("zero_valid",    32'(rx_valid), 32'd0);
    check("zero_overflow", 32'(overflow), 32'd0);
    tick(1);
    check("zero_done_pulse", 32'(done), 32'd0);

    // Restart mid-transfer discards partial shift state.
    start_xfer(16'd4);
    strobe(4'hF); strobe(4'hF); strobe(4'hF);
    push_exp(32'h01234567, 3'd4, 1'b1);
    start_xfer(16'd4);
    check("restart_busy", 32'(busy), 32'd1);
    send_byte(4, 8'h01); send_byte(4, 8'h23); send_byte(4, 8'h45); send_byte(4, 8'h67);
    check("restart_data", rx_data, 32'h01234567);
    tick(2);

    // Reset mid-transfer with an undelivered word pending.
    rx_ready = 1'b0;
    start_xfer(16'd8);
    send_byte(4, 8'h99); send_byte(4, 8'h88); send_byte(4, 8'h77);
    send_byte(4, 8'h66); send_byte(4, 8'h55);
    check("pre_rst_valid", 32'(rx_valid), 32'd1);
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    tick(2);
    rst = 1'b0;
    rx_ready = 1'b1;
    push_exp(32'hCAFEF00D, 3'd4, 1'b1);
    start_xfer(16'd4);
    send_byte(4, 8'hCA); send_byte(4, 8'hFE); send_byte(4, 8'hF0); send_byte(4, 8'h0D);
    check("post_rst_data", rx_data, 32'hCAFEF00D);
    tick(3);

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
